// File: rtl/xy_capture_pkg.sv
// Shared types for the XY capture path: FSM states, the stored point format
// and the trigger-crossing test.
package xy_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TRIG,
        CAPTURE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } point_t;

    // Rising crossing of the threshold between two consecutive kept samples.
    function automatic logic rising_cross(input logic [7:0] prev,
                                          input logic [7:0] cur,
                                          input logic [7:0] level);
        return (prev < level) && (cur >= level);
    endfunction

endpackage

// File: rtl/xy_capture_ram.sv
// Record store: DEPTH points, one write port, one registered read port.
module xy_capture_ram
    import xy_capture_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  point_t        wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output point_t        rdata
);

    point_t mem [DEPTH];

    // Read register only moves on re, so it doubles as the prefetched point.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/xy_capture.sv
// Decimating, edge-triggered XY record capture with a valid/ready byte drain
// (X then Y per point) toward the host link.
module xy_capture
    import xy_capture_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int DECIM_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         i_x,
    input  logic [7:0]         i_y,
    input  logic               i_valid,
    input  logic [DECIM_W-1:0] i_decim,
    input  logic [7:0]         i_trig_level,
    input  logic               i_arm,
    output logic               o_busy,
    output logic               o_done,
    output logic [7:0]         o_data,
    output logic               o_valid,
    input  logic               i_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   LAST_BYTE = (AW + 1)'(2 * DEPTH - 1);

    state_t             state;
    logic [DECIM_W-1:0] decim;
    logic [DECIM_W-1:0] dcnt;
    logic [7:0]         level;
    logic [7:0]         prev_x;
    logic               have_prev;
    logic [AW-1:0]      wptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        out_cnt;
    logic               rd_vld;
    logic               hy_pend;
    logic [7:0]         hold_y;

    logic   sampling, accept, trig, we, re, fire, load, consume, last;
    point_t wdata, rdata;

    always_comb begin
        sampling = (state == WAIT_TRIG || state == CAPTURE) && i_valid;
        accept   = sampling && (dcnt == '0);
        trig     = (state == WAIT_TRIG) && accept && have_prev
                   && rising_cross(prev_x, i_x, level);
        we       = trig || ((state == CAPTURE) && accept);
        wdata    = '{x: i_x, y: i_y};

        fire     = o_valid && i_ready;
        load     = (state == DRAIN) && (!o_valid || i_ready);
        consume  = load && !hy_pend && rd_vld;
        // Refill the read register only once its point has moved to the output side.
        re       = (state == DRAIN) && !rd_ptr[AW] && (!rd_vld || consume);
        last     = fire && (out_cnt == LAST_BYTE);
    end

    xy_capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk_i),
        .we    (we),
        .waddr (wptr),
        .wdata (wdata),
        .re    (re),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            decim     <= '0;
            dcnt      <= '0;
            level     <= '0;
            prev_x    <= '0;
            have_prev <= 1'b0;
            wptr      <= '0;
            rd_ptr    <= '0;
            out_cnt   <= '0;
            rd_vld    <= 1'b0;
            hy_pend   <= 1'b0;
            hold_y    <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_arm) begin
                        decim     <= i_decim;
                        level     <= i_trig_level;
                        dcnt      <= '0;
                        wptr      <= '0;
                        have_prev <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (sampling) dcnt <= (dcnt == decim) ? '0 : dcnt + 1'b1;
                    if (accept) begin
                        prev_x    <= i_x;
                        have_prev <= 1'b1;
                    end
                    if (trig) begin
                        wptr  <= wptr + 1'b1;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (sampling) dcnt <= (dcnt == decim) ? '0 : dcnt + 1'b1;
                    if (accept) begin
                        wptr <= wptr + 1'b1;
                        if (wptr == LAST_ADDR) begin
                            rd_ptr  <= '0;
                            out_cnt <= '0;
                            rd_vld  <= 1'b0;
                            hy_pend <= 1'b0;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (re) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        rd_vld <= 1'b1;
                    end else if (consume) begin
                        rd_vld <= 1'b0;
                    end
                    // Y of the point on the output goes next; otherwise pull the prefetched point.
                    if (load) begin
                        if (hy_pend) begin
                            o_data  <= hold_y;
                            o_valid <= 1'b1;
                            hy_pend <= 1'b0;
                        end else if (rd_vld) begin
                            o_data  <= rdata.x;
                            hold_y  <= rdata.y;
                            hy_pend <= 1'b1;
                            o_valid <= 1'b1;
                        end else begin
                            o_valid <= 1'b0;
                        end
                    end
                    if (fire) out_cnt <= out_cnt + 1'b1;
                    if (last) begin
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xy_capture.sv
// Record-level bench: table of capture scenarios checked against a sample-list
// reference model, plus hand sequences for reset and level-0 corners.
module tb_xy_capture;

    localparam int DEPTH   = 256;
    localparam int DECIM_W = 16;
    localparam int NBYTES  = 2 * DEPTH;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         x = '0, y = '0, level = '0;
    logic               valid = 1'b0, arm = 1'b0, ready = 1'b0;
    logic [DECIM_W-1:0] decim = '0;
    logic               busy, done, ovalid;
    logic [7:0]         odata;

    xy_capture #(.DEPTH(DEPTH), .DECIM_W(DECIM_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .i_x          (x),
        .i_y          (y),
        .i_valid      (valid),
        .i_decim      (decim),
        .i_trig_level (level),
        .i_arm        (arm),
        .o_busy       (busy),
        .o_done       (done),
        .o_data       (odata),
        .o_valid      (ovalid),
        .i_ready      (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        byte unsigned x;
        byte unsigned y;
    } samp_t;

    // mode: 0 ramp, 1 random, 2 trigger qualification; -1 = no hand value
    typedef struct {
        int decim;
        int level;
        int mode;
        int ready_pct;
        bit gaps;
        bit arm_spam;
        int rst_after;
        int exp_x0;
        int exp_y0;
        int exp_x1;
    } vec_t;

    int           errors = 0;
    int           checks = 0;
    samp_t        log_q[$];
    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    int           kidx;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: keep every (dec+1)-th valid sample, find the first rising
    // crossing between consecutive kept samples, record DEPTH kept samples.
    function automatic void build_expected(input int dec, input int lvl);
        samp_t pts[$];
        bit    have = 0;
        bit    trig = 0;
        int    prev = 0;
        exp_q.delete();
        foreach (log_q[i]) begin
            if (pts.size() == DEPTH) break;
            if (i % (dec + 1) != 0) continue;
            if (trig) pts.push_back(log_q[i]);
            else if (have && prev < lvl && int'(log_q[i].x) >= lvl) begin
                trig = 1;
                pts.push_back(log_q[i]);
            end else begin
                prev = int'(log_q[i].x);
                have = 1;
            end
        end
        foreach (pts[j]) begin
            exp_q.push_back(pts[j].x);
            exp_q.push_back(pts[j].y);
        end
    endfunction

    task automatic drive_sample(input int mode, input bit en);
        samp_t s;
        if (!en) begin
            valid = 1'b0;
            x = 8'($urandom);
            y = 8'($urandom);
            return;
        end
        valid = 1'b1;
        case (mode)
            0: begin x = 8'(kidx); y = 8'(kidx); end
            1: begin x = 8'($urandom); y = 8'($urandom); end
            default: begin
                if (kidx < 40)       x = 8'd200;
                else if (kidx == 40) x = 8'd10;
                else if (kidx == 41) x = 8'd150;
                else                 x = 8'($urandom);
                y = 8'(kidx);
            end
        endcase
        kidx++;
        s.x = x;
        s.y = y;
        log_q.push_back(s);
    endtask

    task automatic run_record(input vec_t v, input int idx);
        int           cyc = 0, stab_err = 0, bubbles = 0, mism = 0, first_bad = -1, viol = 0;
        bit           started = 0, prev_stall = 0, finished = 0, reset_seen = 0;
        byte unsigned prev_data = 0;
        log_q.delete();
        got_q.delete();
        kidx = 0;
        @(negedge clk);
        check($sformatf("rec%0d idle busy", idx), int'(busy), 0);
        arm = 1'b1; decim = DECIM_W'(v.decim); level = 8'(v.level);
        valid = 1'b0; ready = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check($sformatf("rec%0d busy after arm", idx), int'(busy), 1);
        while (cyc < 30000) begin
            cyc++;
            if (prev_stall && (!ovalid || odata != prev_data)) stab_err++;
            if (started && !ovalid && got_q.size() < NBYTES) bubbles++;
            if (done) begin
                finished = 1;
                check($sformatf("rec%0d busy at done", idx), int'(busy), 0);
                check($sformatf("rec%0d byte count at done", idx), got_q.size(), NBYTES);
                break;
            end
            ready = ($urandom_range(99) < v.ready_pct);
            drive_sample(v.mode, v.gaps ? cyc[0] : 1'b1);
            arm = v.arm_spam && busy && (cyc % 37 == 0);
            if (ovalid && ready) begin
                got_q.push_back(odata);
                started = 1;
            end
            prev_stall = ovalid && !ready;
            prev_data  = odata;
            if (v.rst_after >= 0 && got_q.size() == v.rst_after) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; arm = 1'b0; valid = 1'b0;
                check($sformatf("rec%0d valid after reset", idx), int'(ovalid), 0);
                check($sformatf("rec%0d busy after reset", idx), int'(busy), 0);
                for (int i = 0; i < 30; i++) begin
                    if (done || ovalid || busy) viol++;
                    @(negedge clk);
                end
                check($sformatf("rec%0d quiet after reset", idx), viol, 0);
                reset_seen = 1;
                break;
            end
            @(negedge clk);
        end
        arm = 1'b0; valid = 1'b0; ready = 1'b1;
        if (reset_seen) return;
        if (!finished) begin
            check($sformatf("rec%0d timeout", idx), 0, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        build_expected(v.decim, v.level);
        check($sformatf("rec%0d model length", idx), exp_q.size(), NBYTES);
        foreach (exp_q[i]) begin
            if (i >= got_q.size() || got_q[i] != exp_q[i]) begin
                if (first_bad < 0) first_bad = i;
                mism++;
            end
        end
        if (mism != 0 && first_bad < got_q.size())
            $display("FAIL rec%0d stream: first bad byte %0d got %0d expected %0d",
                     idx, first_bad, got_q[first_bad], exp_q[first_bad]);
        check($sformatf("rec%0d stream mismatches", idx), mism, 0);
        check($sformatf("rec%0d stability", idx), stab_err, 0);
        if (v.ready_pct == 100) check($sformatf("rec%0d bubbles", idx), bubbles, 0);
        if (v.exp_x0 >= 0 && got_q.size() >= 3) begin
            check($sformatf("rec%0d X0", idx), got_q[0], v.exp_x0);
            if (v.exp_y0 >= 0) check($sformatf("rec%0d Y0", idx), got_q[1], v.exp_y0);
            if (v.exp_x1 >= 0) check($sformatf("rec%0d X1", idx), got_q[2], v.exp_x1);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || ovalid || busy) viol++;
        end
        check($sformatf("rec%0d idle after done", idx), viol, 0);
    endtask

    vec_t vecs[9];

    initial begin
        int seen_valid;
        vecs[0] = '{0,   128, 0, 100, 0, 0, -1,  128, 128, 129};
        vecs[1] = '{3,   128, 0, 100, 0, 0, -1,  128, 128, 132};
        vecs[2] = '{0,   128, 2, 100, 0, 0, -1,  150, -1,  -1};
        vecs[3] = '{0,   128, 0, 30,  0, 0, -1,  128, 128, 129};
        vecs[4] = '{0,   128, 0, 60,  1, 1, -1,  128, 128, 129};
        vecs[5] = '{0,   128, 0, 100, 0, 0, 100, -1,  -1,  -1};
        vecs[6] = '{0,   128, 0, 100, 0, 0, -1,  128, 128, 129};
        vecs[7] = '{1,   77,  1, 50,  0, 1, -1,  -1,  -1,  -1};
        vecs[8] = '{2,   200, 1, 100, 1, 0, -1,  -1,  -1,  -1};

        repeat (3) @(negedge clk);
        check("reset busy",  int'(busy),   0);
        check("reset done",  int'(done),   0);
        check("reset valid", int'(ovalid), 0);
        check("reset data",  int'(odata),  0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_record(vecs[i], i);

        // Level 0 can never produce a crossing: stays armed, emits nothing.
        @(negedge clk);
        arm = 1'b1; decim = '0; level = 8'd0;
        @(negedge clk);
        arm = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 600; i++) begin
            valid = 1'b1; x = 8'($urandom); y = 8'($urandom);
            @(negedge clk);
            if (ovalid || done) seen_valid++;
        end
        valid = 1'b0;
        check("level0 no output", seen_valid, 0);
        check("level0 still busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("level0 busy after reset", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xy_capture.md
# xy_capture

Receive-side counterpart of the XY test-pattern generator. Accepts the 8-bit X/Y sample stream, decimates it, waits for a rising-edge trigger on X, stores a fixed-length record in on-chip RAM, then drains the record as a byte stream (X then Y per point) over a valid/ready interface toward the host link. Sits between the pattern/ADC source and the UART/readout path of the virtual scope.

## Interface

- `DEPTH`, 256: points per record; power of two, 4..4096.
- `DECIM_W`, 16: width of the decimation setting.
- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `i_x`  in  8  X sample, unsigned.
- `i_y`  in  8  Y sample, unsigned.
- `i_valid`  in  1  X/Y sample present this cycle.
- `i_decim`  in  DECIM_W  keep 1 of every `i_decim`+1 valid samples; sampled on arm.
- `i_trig_level`  in  8  X trigger threshold; sampled on arm.
- `i_arm`  in  1  single-cycle start request.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_done`  out  1  one-cycle pulse after the last byte is accepted.
- `o_data`  out  8  drain byte.
- `o_valid`  out  1  `o_data` valid.
- `i_ready`  in  1  downstream accepts `o_data`.

## Operation

- FSM: IDLE -> WAIT_TRIG -> CAPTURE -> DRAIN -> IDLE.
- IDLE: `i_arm`=1 latches `i_decim`, `i_trig_level`; clears decimation counter, write pointer, "have previous" flag; next state WAIT_TRIG. `i_arm` in any other state is ignored.
- Decimation: counter counts valid samples 0..decim; a sample is "accepted" when counter==0; counter wraps to 0 after decim. decim=0 accepts every valid sample.
- WAIT_TRIG: on each accepted sample, trigger = have_prev && prev_x < level && x >= level (unsigned compare). First accepted sample after arm only sets prev_x/have_prev, cannot trigger. On trigger, that sample is written to address 0 and state -> CAPTURE.
- CAPTURE: each accepted sample written at write pointer (1..DEPTH-1). After address DEPTH-1 written, state -> DRAIN. Samples with `i_valid`=0 are ignored entirely.
- DRAIN: bytes emitted in order X[0], Y[0], X[1], Y[1] ... Y[DEPTH-1]: 2*DEPTH bytes. Byte transferred when `o_valid && i_ready`. After last transfer: `o_done`=1 for one cycle, state -> IDLE. Input samples ignored during DRAIN.
- Level 0 never triggers (x >= 0 always, prev_x < 0 impossible); documented, not an error.

## Timing

- Reset values: `o_busy`=0, `o_done`=0, `o_valid`=0, `o_data`=0; FSM IDLE; RAM contents undefined.
- `o_busy` rises the cycle after `i_arm` is sampled in IDLE; falls in the same cycle `o_done` pulses.
- Trigger sample written in the cycle it is presented; CAPTURE entered next cycle.
- RAM read latency 1 cycle. First `o_valid` no later than 2 cycles after DRAIN entry.
- Valid/ready: once `o_valid`=1, `o_data` and `o_valid` stay stable until accepted; `o_valid` never depends combinationally on `i_ready`. With `i_ready` held high, one byte per cycle after first byte (no bubbles; RAM prefetch of next point overlaps Y byte).
- `i_ready`=0 may last indefinitely; no data loss.
- `rst_i` mid-capture or mid-drain: next cycle IDLE, `o_valid`=0, record discarded, no `o_done`.

## Structure

- Package `xy_capture_pkg`: FSM state enum (IDLE, WAIT_TRIG, CAPTURE, DRAIN), point typedef (struct of x,y bytes, 16 bits).
- Sub-module `xy_capture_ram`: simple dual-port RAM, DEPTH x 16, one write port, one registered read port, no reset on contents.
- Top holds FSM, decimation counter, trigger compare, write pointer, read pointer, byte-select, output register.

## Test plan

- Ramp: x=y=0..255 repeating every valid cycle, decim=0, level=128, DEPTH=256, ready always 1 -> first bytes 0x80,0x80,0x81,0x81; 512 bytes contiguous; `o_done` one pulse; `o_busy` low after.
- Decimation: same ramp, decim=3, level=128 -> record X sequence 128,132,136,...; wrap 252 -> 0 (no retrigger mid-capture).
- Trigger qualification: arm when x already 200 then holds 200 -> no capture (stays WAIT_TRIG); x drops to 10 then 150 -> trigger on 150, X[0]=150.
- Back-pressure: random `i_ready` (~30% high) during drain -> byte stream identical to ready=1 case; `o_data` stable whenever `o_valid && !i_ready`.
- Gaps/arm ignore: `i_valid` toggling 1/0 plus `i_arm` pulses during CAPTURE and DRAIN -> invalid cycles not stored, extra arms ignored, single record output.
- Reset mid-drain after 100 bytes -> `o_valid`=0, `o_busy`=0 next cycle, no `o_done`; fresh arm produces a correct full record.
